// File: rtl/yscaler_line_ctrl.sv
// Vertical-scaler line sequencer: buffers one input line, consults the line-decision counter, emits/repeats/drops it.
// Latency: line is emitted after SETTLE+DECIDE (2 cycles) plus 2 cycles of RAM read / skid pipeline.
// Backpressure: input stalled (tready=0) outside IDLE/FILL; output holds data under !m_axis_tready with no bubbles or loss.
module yscaler_line_ctrl #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_RESO_WIDTH  = 10,
  parameter int C_MAX_WIDTH   = 1024
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [C_RESO_WIDTH-1:0]  src_width,
  input  logic [C_RESO_WIDTH-1:0]  src_height,
  input  logic [C_RESO_WIDTH-1:0]  dst_height,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     sc_resetn,
  output logic [C_RESO_WIDTH-1:0]  sc_ori_size,
  output logic [C_RESO_WIDTH-1:0]  sc_scale_size,
  output logic                     sc_update,
  input  logic                     sc_ovalid,
  input  logic                     sc_repeat,
  output logic                     frame_done,
  output logic                     err
);
  localparam int PW = C_PIXEL_WIDTH;
  localparam int RW = C_RESO_WIDTH;
  localparam int AW = (C_MAX_WIDTH > 1) ? $clog2(C_MAX_WIDTH) : 1;
  localparam logic [RW-1:0] ONE_RW = {{(RW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SETTLE, S_DECIDE, S_EMIT} state_t;
  state_t state, state_nxt;

  // frame geometry latched at SOF, line/pixel counters
  logic [RW-1:0] width_q, height_q, dheight_q;
  logic [RW-1:0] wr_idx, rd_idx, in_line, out_line, out_line_inc;
  logic          drop_q, reemit_q, err_q, frame_done_q;

  // line RAM and its registered read stage
  logic [PW-1:0] line_buf [C_MAX_WIDTH];
  logic [PW-1:0] rd_dat;
  logic          rd_vld, rd_user, rd_last;

  // 2-entry output skid buffer
  logic [PW-1:0] sk_dat [2];
  logic [1:0]    sk_user, sk_last, sk_cnt;
  logic          sk_wp, sk_rp;

  // decode signals
  logic          acc, sof, sizes_ok;
  logic [RW-1:0] pix_pos, width_eff;
  logic [RW:0]   pix_pos_p1;
  logic          last_pix, line_end, early, drop_set;
  logic          start, pix_wr, drop_clr, upd, err_set, fd_set, go_reemit;
  logic          pop, last_pop, rd_en;
  logic [2:0]    occ;

  assign s_axis_tready = (state == S_IDLE) || (state == S_FILL);
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign sof           = acc && s_axis_tuser;
  assign sizes_ok      = (src_width != '0) && (src_height != '0) && (dst_height != '0);

  // An SOF beat is always pixel 0 of a new frame and is judged against the new width.
  assign pix_pos    = sof ? '0 : wr_idx;
  assign width_eff  = sof ? src_width : width_q;
  assign pix_pos_p1 = {1'b0, pix_pos} + {{RW{1'b0}}, 1'b1};
  assign last_pix   = (pix_pos_p1 == {1'b0, width_eff});
  assign line_end   = s_axis_tlast || last_pix;
  assign early      = s_axis_tlast && !last_pix;
  assign drop_set   = last_pix && !s_axis_tlast;

  assign m_axis_tvalid = (sk_cnt != 2'd0);
  assign m_axis_tdata  = sk_dat[sk_rp];
  assign m_axis_tuser  = sk_user[sk_rp];
  assign m_axis_tlast  = sk_last[sk_rp];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign last_pop      = pop && m_axis_tlast && (state == S_EMIT);
  assign out_line_inc  = out_line + ONE_RW;

  // Occupancy the skid buffer will have once in-flight reads land; keeps it from overflowing.
  assign occ   = {1'b0, sk_cnt} + {2'b00, rd_vld} - {2'b00, pop};
  assign rd_en = (state == S_EMIT) && (rd_idx < width_q) && (occ < 3'd2);

  assign sc_resetn     = (state != S_IDLE);
  assign sc_ori_size   = height_q;
  assign sc_scale_size = dheight_q;
  assign sc_update     = upd;
  assign frame_done    = frame_done_q;
  assign err           = err_q;

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // next-state and per-cycle control decisions
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pix_wr    = 1'b0;
    drop_clr  = 1'b0;
    upd       = 1'b0;
    err_set   = 1'b0;
    fd_set    = 1'b0;
    go_reemit = 1'b0;
    case (state)
      S_IDLE: begin
        if (sof) begin
          if (sizes_ok) begin
            start     = 1'b1;
            state_nxt = line_end ? S_SETTLE : S_FILL;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (sof) begin
          err_set = 1'b1;
          if (sizes_ok) begin
            start     = 1'b1;
            state_nxt = line_end ? S_SETTLE : S_FILL;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (acc && drop_q) begin
          drop_clr = s_axis_tlast;
        end else if (acc) begin
          pix_wr = 1'b1;
          if (line_end) state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: state_nxt = reemit_q ? S_EMIT : S_DECIDE;
      S_DECIDE: begin
        if (sc_ovalid) begin
          state_nxt = S_EMIT;
        end else begin
          upd = 1'b1;
          if (in_line < height_q) begin
            state_nxt = S_FILL;
          end else begin
            err_set   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        if (last_pop) begin
          upd = 1'b1;
          if (out_line_inc == dheight_q) begin
            fd_set    = 1'b1;
            state_nxt = S_IDLE;
          end else if (sc_repeat || (in_line == height_q)) begin
            go_reemit = 1'b1;
            state_nxt = S_SETTLE;
          end else begin
            state_nxt = S_FILL;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if ((start || pix_wr) && early) err_set = 1'b1;
  end

  // frame geometry, line counters, error and done flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      width_q      <= '0;
      height_q     <= '0;
      dheight_q    <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      in_line      <= '0;
      out_line     <= '0;
      drop_q       <= 1'b0;
      reemit_q     <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= fd_set;
      if (err_set) err_q <= 1'b1;
      if (start) begin
        width_q   <= src_width;
        height_q  <= src_height;
        dheight_q <= dst_height;
        out_line  <= '0;
      end
      if (start || pix_wr) begin
        wr_idx <= line_end ? '0 : pix_pos_p1[RW-1:0];
        drop_q <= drop_set;
        if (start)         in_line <= line_end ? ONE_RW : '0;
        else if (line_end) in_line <= in_line + ONE_RW;
      end else if (drop_clr) begin
        drop_q <= 1'b0;
      end
      if (state != S_EMIT) rd_idx <= '0;
      else if (rd_en)      rd_idx <= rd_idx + ONE_RW;
      if (last_pop) out_line <= out_line_inc;
      if (last_pop)                reemit_q <= go_reemit;
      else if (state != S_SETTLE) reemit_q <= 1'b0;
    end
  end

  // line RAM: write on accepted pixels, registered read for emission
  always_ff @(posedge clk) begin
    if (start || pix_wr) line_buf[AW'(pix_pos)] <= s_axis_tdata;
    if (rd_en)           rd_dat <= line_buf[AW'(rd_idx)];
  end

  // sideband travelling alongside the RAM read
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_vld  <= 1'b0;
      rd_user <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_vld  <= rd_en;
      rd_user <= (out_line == '0) && (rd_idx == '0);
      rd_last <= ((rd_idx + ONE_RW) == width_q);
    end
  end

  // skid buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sk_wp  <= 1'b0;
      sk_rp  <= 1'b0;
      sk_cnt <= 2'd0;
    end else begin
      if (rd_vld) sk_wp <= ~sk_wp;
      if (pop)    sk_rp <= ~sk_rp;
      sk_cnt <= sk_cnt + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

  // skid buffer storage
  always_ff @(posedge clk) begin
    if (rd_vld) begin
      sk_dat[sk_wp]  <= rd_dat;
      sk_user[sk_wp] <= rd_user;
      sk_last[sk_wp] <= rd_last;
    end
  end
endmodule

// File: tb/tb_yscaler_line_ctrl.sv
// Bench for yscaler_line_ctrl: scripted decision-counter model, scoreboard of expected output beats.
// Latency: n/a (testbench).
// Backpressure: output ready held high or randomised per cycle.
module tb_yscaler_line_ctrl;
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn = 1'b0;
  logic [9:0] src_width = 10'd4, src_height = 10'd4, dst_height = 10'd4;
  logic       s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tuser, m_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic       sc_resetn, sc_update, sc_ovalid, sc_repeat, frame_done, err;
  logic [9:0] sc_ori_size, sc_scale_size;

  yscaler_line_ctrl dut (
    .clk(clk), .resetn(resetn),
    .src_width(src_width), .src_height(src_height), .dst_height(dst_height),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .sc_resetn(sc_resetn), .sc_ori_size(sc_ori_size), .sc_scale_size(sc_scale_size),
    .sc_update(sc_update), .sc_ovalid(sc_ovalid), .sc_repeat(sc_repeat),
    .frame_done(frame_done), .err(err)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scripted decision counter: decision k uses ov_tab[k] / rp_tab[k]
  logic       ov_tab [8];
  logic       rp_tab [8];
  logic [2:0] upd_cnt;
  always @(posedge clk) begin
    if (!sc_resetn)     upd_cnt <= 3'd0;
    else if (sc_update) upd_cnt <= upd_cnt + 3'd1;
  end
  assign sc_ovalid = ov_tab[upd_cnt];
  assign sc_repeat = rp_tab[upd_cnt];

  task automatic set_script(input logic [3:0] ov, input logic [3:0] rp);
    for (int i = 0; i < 8; i++) begin
      ov_tab[i] = (i < 4) ? ov[i] : 1'b1;
      rp_tab[i] = (i < 4) ? rp[i] : 1'b0;
    end
  endtask

  // scoreboard: {tuser, tlast, tdata}
  logic [9:0] exp_q [$];
  logic [7:0] lines [4][4];
  logic       rnd_rdy = 1'b0, hold_rdy = 1'b1;
  int         fd_cnt = 0, upd_tot = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;

  // output monitor: drive ready, then compare accepted beats and hold-stability
  always @(negedge clk) begin
    m_axis_tready = rnd_rdy ? ($urandom_range(0, 1) == 1) : hold_rdy;
    #1;
    if (resetn) begin
      if (sc_update)  upd_tot++;
      if (frame_done) fd_cnt++;
      if (prev_stall)
        check("hold", {21'b0, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {21'b0, 1'b1, prev_beat});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 32'd1);
        else check("pix", {22'b0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'b0, exp_q.pop_front()});
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic fill_lines(input logic [7:0] base);
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 4; k++) lines[l][k] = base + 8'(l * 4 + k);
  endtask

  task automatic push_line(input int l, input logic first);
    for (int k = 0; k < 4; k++) exp_q.push_back({first && (k == 0), k == 3, lines[l][k]});
  endtask

  task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
    while (!s_axis_tready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!s_axis_tready) check("in_ready", {31'b0, s_axis_tready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_line(input int l, input logic sof);
    for (int k = 0; k < 4; k++) send_beat(lines[l][k], sof && (k == 0), k == 3);
  endtask

  task automatic idle_in;
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int t;
    t = 0;
    while (fd_cnt < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_done"}, 32'(fd_cnt), 32'(target));
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    resetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_tready", {31'b0, s_axis_tready}, 32'd1);
    check("rst_mvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst_scresetn", {31'b0, sc_resetn}, 32'd0);
    check("rst_scupdate", {31'b0, sc_update}, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    resetn = 1'b1;
  endtask

  initial begin
    int u0, t;
    set_script(4'b1111, 4'b0000);
    do_reset();

    // 1:1 4x4
    fill_lines(8'h10);
    u0 = upd_tot;
    for (int l = 0; l < 4; l++) push_line(l, l == 0);
    for (int l = 0; l < 4; l++) send_line(l, l == 0);
    idle_in();
    wait_done(1, "one2one");
    check("one2one_upd", 32'(upd_tot - u0), 32'd4);
    check("one2one_err", {31'b0, err}, 32'd0);

    // upscale 2 -> 4: L0, L1, L1 (repeat), L1 (extension)
    src_height = 10'd2; dst_height = 10'd4;
    set_script(4'b1111, 4'b0110);
    fill_lines(8'h40);
    u0 = upd_tot;
    push_line(0, 1'b1); push_line(1, 1'b0); push_line(1, 1'b0); push_line(1, 1'b0);
    send_line(0, 1'b1); send_line(1, 1'b0);
    idle_in();
    wait_done(2, "up");
    check("up_upd", 32'(upd_tot - u0), 32'd4);
    check("up_ori", 32'(sc_ori_size), 32'd2);
    check("up_scale", 32'(sc_scale_size), 32'd4);

    // downscale 4 -> 2: lines 0 and 2 dropped
    src_height = 10'd4; dst_height = 10'd2;
    set_script(4'b1010, 4'b0000);
    fill_lines(8'h60);
    u0 = upd_tot;
    push_line(1, 1'b1); push_line(3, 1'b0);
    for (int l = 0; l < 4; l++) send_line(l, l == 0);
    idle_in();
    wait_done(3, "down");
    check("down_upd", 32'(upd_tot - u0), 32'd4);

    // 1:1 under random output backpressure
    dst_height = 10'd4;
    set_script(4'b1111, 4'b0000);
    fill_lines(8'h80);
    rnd_rdy = 1'b1;
    for (int l = 0; l < 4; l++) push_line(l, l == 0);
    for (int l = 0; l < 4; l++) send_line(l, l == 0);
    idle_in();
    wait_done(4, "rnd");
    rnd_rdy = 1'b0;
    check("rnd_err", {31'b0, err}, 32'd0);

    // early tlast on line 1: stale tail pixels come from line 0
    src_height = 10'd3; dst_height = 10'd3;
    fill_lines(8'hA0);
    push_line(0, 1'b1);
    exp_q.push_back({2'b00, lines[1][0]}); exp_q.push_back({2'b00, lines[1][1]});
    exp_q.push_back({2'b00, lines[0][2]}); exp_q.push_back({2'b01, lines[0][3]});
    push_line(2, 1'b0);
    send_line(0, 1'b1);
    send_beat(lines[1][0], 1'b0, 1'b0);
    send_beat(lines[1][1], 1'b0, 1'b1);
    send_line(2, 1'b0);
    idle_in();
    wait_done(5, "early");
    check("early_err", {31'b0, err}, 32'd1);

    // mid-frame SOF restarts the frame
    do_reset();
    src_height = 10'd4; dst_height = 10'd4;
    fill_lines(8'hC0);
    for (int l = 0; l < 4; l++) push_line(l, l == 0);
    send_beat(8'h55, 1'b1, 1'b0);
    send_beat(8'h56, 1'b0, 1'b0);
    for (int l = 0; l < 4; l++) send_line(l, l == 0);
    idle_in();
    wait_done(6, "midsof");
    check("midsof_err", {31'b0, err}, 32'd1);

    // reset while a line is waiting to be emitted
    hold_rdy = 1'b0;
    fill_lines(8'hE0);
    send_line(0, 1'b1);
    idle_in();
    t = 0;
    while (!m_axis_tvalid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("emit_vld", {31'b0, m_axis_tvalid}, 32'd1);
    do_reset();
    hold_rdy = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
